// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - state codes, screen geometry and brick-array width for the game sequencer
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOSE  = 3'd3,
    ST_WIN   = 3'd4,
    ST_OVER  = 3'd5
  } game_state_e;

  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int BALL_W      = 16;
  localparam int BALL_H      = 10;
  localparam int PADDLE_Y    = 467;
  localparam int SERVE_Y     = 455;
  localparam int MISS_LIMIT  = 530;
  localparam int SERVE_X_OFS = 40;
  localparam int BRICK_W     = 1440;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - free-running divider that strobes tick_o for one clk every TICK_DIV cycles
module frame_tick_gen #(
  parameter int TICK_DIV = 1666666
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game FSM and registered ball/brick state, committed once per game tick
// Score accumulation is present only when GAME_SEQ_SCORE_EN is defined; otherwise score is 0.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int TICK_DIV   = 1666666,
  parameter int INIT_LIVES = 3,
  parameter int INIT_VX    = 4,
  parameter int INIT_VY    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               launch,
  input  logic [9:0]         board_x,
  input  logic [BRICK_W-1:0] init_bricks,
  input  logic [9:0]         next_ball_x,
  input  logic [9:0]         next_ball_y,
  input  logic [9:0]         next_ball_vx,
  input  logic [9:0]         next_ball_vy,
  input  logic [1:0]         next_ball_dir,
  input  logic [BRICK_W-1:0] next_bricks,
  input  logic [3:0]         collision_trig,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [9:0]         ball_vx,
  output logic [9:0]         ball_vy,
  output logic [1:0]         ball_dir,
  output logic [BRICK_W-1:0] bricks,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [15:0]        score,
  output logic               tick
);

  game_state_e        state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [BRICK_W-1:0] bricks_q, bricks_d;
  logic [9:0]         bx_q, bx_d, by_q, by_d, vx_q, vx_d, vy_q, vy_d;
  logic [1:0]         dir_q, dir_d;
  logic               pend_q, pend_d;
  logic               score_clr, score_add;
  logic               miss;
  logic [11:0]        miss_sum;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  // Miss looks at the ball as it is now, before this tick's commit.
  assign miss_sum = 12'(by_q) + 12'(vy_q) + 12'(BALL_H);
  assign miss     = dir_q[0] && (miss_sum > 12'(MISS_LIMIT));

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    bricks_d  = bricks_q;
    bx_d      = bx_q;
    by_d      = by_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    dir_d     = dir_q;
    score_clr = 1'b0;
    score_add = 1'b0;
    case (state_q)
      ST_MENU: if (start) begin
        bricks_d  = init_bricks;
        lives_d   = 3'(INIT_LIVES);
        score_clr = 1'b1;
        state_d   = ST_SERVE;
      end
      ST_SERVE: if (tick) begin
        bx_d  = board_x + 10'(SERVE_X_OFS);
        by_d  = 10'(SERVE_Y);
        vx_d  = 10'(INIT_VX);
        vy_d  = 10'(INIT_VY);
        dir_d = 2'b10;
        if (pend_q || launch) state_d = ST_PLAY;
      end
      ST_PLAY: if (tick) begin
        bx_d      = next_ball_x;
        by_d      = next_ball_y;
        vx_d      = next_ball_vx;
        vy_d      = next_ball_vy;
        dir_d     = next_ball_dir;
        bricks_d  = next_bricks;
        score_add = 1'b1;
        if (next_bricks == '0) state_d = ST_WIN;
        else if (miss)         state_d = ST_LOSE;
      end
      ST_LOSE: if (tick) begin
        lives_d = lives_q - 3'd1;
        state_d = (lives_d == 3'd0) ? ST_OVER : ST_SERVE;
      end
      ST_WIN, ST_OVER: if (start) state_d = ST_MENU;
      default: state_d = ST_MENU;
    endcase
    // A launch seen in SERVE waits for the next tick; any exit from SERVE drops it.
    pend_d = (state_d == ST_SERVE) ? (pend_q | ((state_q == ST_SERVE) & launch)) : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_MENU;
      lives_q  <= 3'(INIT_LIVES);
      bricks_q <= '0;
      bx_q     <= 10'(H_RES / 2);
      by_q     <= 10'(SERVE_Y);
      vx_q     <= 10'(INIT_VX);
      vy_q     <= 10'(INIT_VY);
      dir_q    <= 2'b10;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      bricks_q <= bricks_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
    end
  end

`ifdef GAME_SEQ_SCORE_EN
  logic [15:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (score_clr)      score_d = '0;
    else if (score_add) score_d = sat_add16(score_q, collision_trig);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end

  assign score = score_q;
`else
  logic unused_score;
  assign unused_score = ^{collision_trig, score_clr, score_add};
  assign score = '0;
`endif

  assign state    = state_q;
  assign lives    = lives_q;
  assign bricks   = bricks_q;
  assign ball_x   = bx_q;
  assign ball_y   = by_q;
  assign ball_vx  = vx_q;
  assign ball_vy  = vy_q;
  assign ball_dir = dir_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized bench for game_sequencer against a rule-level reference model
module tb_game_sequencer;

  localparam int TD     = 4;
  localparam int INIT_L = 3;
  localparam int IVX    = 4;
  localparam int IVY    = 4;
  localparam int BW     = 1440;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          launch = 1'b0;
  logic [9:0]    board_x = '0;
  logic [BW-1:0] init_bricks = '0;
  logic [9:0]    next_ball_x = '0, next_ball_y = '0, next_ball_vx = '0, next_ball_vy = '0;
  logic [1:0]    next_ball_dir = '0;
  logic [BW-1:0] next_bricks = '0;
  logic [3:0]    collision_trig = '0;

  logic [9:0]    ball_x, ball_y, ball_vx, ball_vy;
  logic [1:0]    ball_dir;
  logic [BW-1:0] bricks;
  logic [2:0]    state, lives;
  logic [15:0]   score;
  logic          tick;

  game_sequencer #(.TICK_DIV(TD), .INIT_LIVES(INIT_L), .INIT_VX(IVX), .INIT_VY(IVY)) dut (
    .clk(clk), .rst(rst), .start(start), .launch(launch), .board_x(board_x),
    .init_bricks(init_bricks), .next_ball_x(next_ball_x), .next_ball_y(next_ball_y),
    .next_ball_vx(next_ball_vx), .next_ball_vy(next_ball_vy), .next_ball_dir(next_ball_dir),
    .next_bricks(next_bricks), .collision_trig(collision_trig),
    .ball_x(ball_x), .ball_y(ball_y), .ball_vx(ball_vx), .ball_vy(ball_vy), .ball_dir(ball_dir),
    .bricks(bricks), .state(state), .lives(lives), .score(score), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: game rules expressed directly on plain integers.
  int            m_state, m_lives, m_score, m_bx, m_by, m_vx, m_vy, m_dir, tcnt;
  logic [BW-1:0] m_bricks;
  bit            m_pend;

  int p_start, p_launch, p_clear, trig_fixed;
  bit force_up;

  function automatic logic [BW-1:0] rand_bricks();
    logic [BW-1:0] v;
    for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = INIT_L; m_score = 0; m_bricks = '0;
    m_bx = 320; m_by = 455; m_vx = IVX; m_vy = IVY; m_dir = 2;
    m_pend = 0; tcnt = 0;
  endtask

  task automatic model_step();
    bit tk, miss;
    int ns;
    tk = (tcnt % TD) == TD - 1;
    tcnt++;
    if (m_state == 1 && launch) m_pend = 1;
    ns = m_state;
    case (m_state)
      0: if (start) begin
        m_bricks = init_bricks; m_lives = INIT_L; m_score = 0; ns = 1;
      end
      1: if (tk) begin
        m_bx = (int'(board_x) + 40) % 1024; m_by = 455; m_vx = IVX; m_vy = IVY; m_dir = 2;
        if (m_pend) ns = 2;
      end
      2: if (tk) begin
        miss = (m_dir % 2 == 1) && (m_by + m_vy + 10 > 530);
        m_bx = int'(next_ball_x); m_by = int'(next_ball_y);
        m_vx = int'(next_ball_vx); m_vy = int'(next_ball_vy);
        m_dir = int'(next_ball_dir); m_bricks = next_bricks;
        m_score = m_score + int'(collision_trig);
        if (m_score > 65535) m_score = 65535;
        if (next_bricks == '0) ns = 4;
        else if (miss) ns = 3;
      end
      3: if (tk) begin
        m_lives = m_lives - 1;
        ns = (m_lives == 0) ? 5 : 1;
      end
      4, 5: if (start) ns = 0;
      default: ns = 0;
    endcase
    m_state = ns;
    if (ns != 1) m_pend = 0;
  endtask

  task automatic check_outputs();
    chk("state", BW'(state), BW'(m_state));
    chk("lives", BW'(lives), BW'(m_lives));
`ifdef GAME_SEQ_SCORE_EN
    chk("score", BW'(score), BW'(m_score));
`else
    chk("score", BW'(score), BW'(0));
`endif
    chk("tick", BW'(tick), BW'((tcnt % TD) == TD - 1));
    chk("ball_x", BW'(ball_x), BW'(m_bx));
    chk("ball_y", BW'(ball_y), BW'(m_by));
    chk("ball_vx", BW'(ball_vx), BW'(m_vx));
    chk("ball_vy", BW'(ball_vy), BW'(m_vy));
    chk("ball_dir", BW'(ball_dir), BW'(m_dir));
    chk("bricks", bricks, m_bricks);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic randomize_inputs();
    start         = ($urandom_range(99) < p_start);
    launch        = ($urandom_range(99) < p_launch);
    board_x       = 10'($urandom_range(1023));
    next_ball_x   = 10'($urandom_range(1023));
    next_ball_y   = 10'($urandom_range(1023));
    next_ball_vx  = 10'($urandom_range(1023));
    next_ball_vy  = 10'($urandom_range(15));
    next_ball_dir = 2'($urandom_range(3));
    if (force_up) next_ball_dir[0] = 1'b0;
    collision_trig = (trig_fixed >= 0) ? 4'(trig_fixed) : 4'($urandom_range(15));
    next_bricks    = ($urandom_range(99) < p_clear) ? '0 : rand_bricks();
    if ($urandom_range(49) == 0) init_bricks = rand_bricks();
  endtask

  // Asynchronous reset asserted between edges; outputs must return to reset values at once.
  task automatic do_reset();
    int hold;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    hold = $urandom_range(1, 3);
    repeat (hold) cycle();
    rst = 1'b0;
  endtask

  initial begin
    p_start = 6; p_launch = 12; p_clear = 8; trig_fixed = -1; force_up = 0;
    init_bricks = rand_bricks();
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    for (int c = 0; c < 4000 && errors < 100; c++) begin
      randomize_inputs();
      if ($urandom_range(299) == 0) do_reset();
      else cycle();
    end

    // Long uninterrupted rally: no misses, no clears, maximum hit weight.
    force_up = 1; trig_fixed = 15; p_start = 20; p_launch = 20; p_clear = 0;
    for (int c = 0; c < 20000 && errors < 100; c++) begin
      randomize_inputs();
      cycle();
    end
`ifdef GAME_SEQ_SCORE_EN
    chk("score_saturated", BW'(score), BW'(16'hFFFF));
`else
    chk("score_saturated", BW'(score), BW'(16'h0000));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-rate controller that sequences the combinational ball/brick datapath. It generates the game tick and owns the game state machine. It holds the registered ball position, velocity, direction and brick array. On each PLAY tick it commits the datapath's next-state outputs and tracks lives and score. It sits between the input/debounce logic and the ball datapath, and drives the `state` input that freezes that datapath in MENU.

## Interface
- TICK_DIV, 1666666 — clk cycles per game tick (60 Hz at 100 MHz)
- INIT_LIVES, 3 — lives loaded at reset and on new game (1..7)
- INIT_VX, 4 — launch horizontal speed
- INIT_VY, 4 — launch vertical speed
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse (debounced): leave MENU/WIN/OVER
- launch  in  1  one-cycle pulse (debounced): serve ball
- board_x  in  10  paddle left x
- init_bricks  in  1440  level pattern, 20 bricks/row × 24 rows, 3 bits each
- next_ball_x, next_ball_y, next_ball_vx, next_ball_vy  in  10 each  datapath next values
- next_ball_dir  in  2  datapath next direction ([1]=right, [0]=down)
- next_bricks  in  1440  datapath next brick array
- collision_trig  in  4  datapath hit weight for this step
- ball_x, ball_y, ball_vx, ball_vy  out  10 each  registered ball state to datapath/renderer
- ball_dir  out  2  registered direction
- bricks  out  1440  registered brick array
- state  out  3  game state
- lives  out  3  remaining lives
- score  out  16  accumulated score
- tick  out  1  one-cycle game-tick strobe

## Operation
- States: MENU=0, SERVE=1, PLAY=2, LOSE=3, WIN=4, OVER=5. Codes 6–7 are unreachable and recover to MENU on the next clk.
- MENU: outputs are held. On `start`: load bricks←init_bricks, lives←INIT_LIVES, score←0, then go to SERVE.
- SERVE, every tick: ball_x←board_x+40, ball_y←455, vx←INIT_VX, vy←INIT_VY, dir←2'b10. On `launch`, go to PLAY.
- PLAY, every tick:
  - Commit all next_* values into the ball registers and `bricks`.
  - score←score+collision_trig, saturating at 16'hFFFF.
  - Miss: dir[0]=1 and ball_y+ball_vy+10 > 530, evaluated on the pre-commit registers. A miss goes to LOSE; the ball registers are still committed.
  - Clear: next_bricks == 0. A clear goes to WIN.
  - Clear and miss on the same tick: WIN takes priority.
- LOSE, one tick: lives←lives−1. If the result is 0, go to OVER; otherwise go to SERVE.
- WIN / OVER: registers are frozen. On `start`, go to MENU.
- `start` is ignored outside MENU/WIN/OVER. `launch` is ignored outside SERVE.

## Timing
- `tick` pulses high for one clk every TICK_DIV cycles. The divider counts 0..TICK_DIV−1 and pulses at terminal count.
- All state transitions and register commits happen on the clk edge where tick=1. The only exception is the `start` from MENU/WIN/OVER, which is acted on at the first clk edge where it is seen, independent of tick.
- `launch` must be captured into a pending flag so it is not lost between ticks. The flag is consumed on the next SERVE tick and cleared on entry to any state other than SERVE.
- The datapath is combinational from the registered outputs. next_* inputs are valid one cycle after any register change, so every tick sees settled inputs.
- Reset values:
  - state=MENU, lives=INIT_LIVES, score=0, bricks=0
  - ball_x=320, ball_y=455, vx=INIT_VX, vy=INIT_VY, dir=2'b10
  - tick=0, divider=0, launch flag=0
- Reset mid-game aborts immediately to the reset values. No tick is issued until TICK_DIV cycles after reset is released.

## Configuration
- GAME_SEQ_SCORE_EN defined: score accumulates as described.
- GAME_SEQ_SCORE_EN undefined: the score register and adder are removed, and `score` is constant 0.

## Structure
- The shared package holds:
  - state encodings
  - screen constants: H=640, V=480, ball 16×10, paddle y=467, serve y=455, miss limit 530
  - the brick-array width of 1440
- One sub-module, `frame_tick_gen` (parameter TICK_DIV), holds the divider and drives `tick`. The FSM and registers stay in `game_sequencer`.

## Test plan
- TICK_DIV=4 (this and all scenarios below): reset, then `start` → state=1, lives=3, bricks=init_bricks. `launch` between ticks → state=2 at the next tick, dir=2'b10.
- PLAY with collision_trig=3 on two ticks → score=6. With score at 16'hFFFE and trig=3 → score=16'hFFFF.
- PLAY with ball_y=520, vy=4, dir[0]=1 → LOSE, then lives=2, then SERVE with ball_x=board_x+40.
- lives=1 and a miss → LOSE, then OVER with lives=0. `launch` in OVER is ignored. `start` → MENU.
- next_bricks=0 and a miss on the same tick → WIN with lives unchanged.
- Assert rst during PLAY → all outputs at reset values within the same cycle. No tick until 4 cycles after release.
